// File: rtl/inst_feeder.sv
// Instruction memory and fetch sequencer that feeds halfword Thumb beats to arm_core.
// Define INST_FEEDER_WAIT_EN to compile in the WAIT state that honours WAIT_CYCLES.
module inst_feeder #(
   parameter int          ADDR_W      = 20,
   parameter int          LANES       = 1,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [15:0] PAD_HW      = 16'hBF00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [ADDR_W-1:0]     load_addr,
   input  logic [15:0]           load_data,
   input  logic [ADDR_W:0]       prog_len,
   input  logic                  start,
   input  logic                  redirect,
   input  logic [ADDR_W-1:0]     redirect_addr,
   input  logic                  out_ready,
   output logic [16*LANES-1:0]   inst_hw,
   output logic                  inst_valid,
   output logic [ADDR_W:0]       pc,
   output logic                  done
);
   localparam int              PW        = ADDR_W + 1;
   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [PW-1:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [PW-1:0]   STEP      = PW'(LANES);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
`ifdef INST_FEEDER_WAIT_EN
   localparam logic [1:0] WAIT = 2'd2;
`endif
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]          state;
   logic [PW-1:0]       len;
   logic [PW-1:0]       len_in;
   logic [PW-1:0]       target;
   logic [PW-1:0]       fetch_addr;
   logic [PW-1:0]       fetch_len;
   logic                busy;
   logic                redir_hit;
   logic                restart;
   logic                launch;
   logic                can_issue;
   logic                fetch;
   logic [16*LANES-1:0] beat;
   logic [15:0]         mem [DEPTH];
`ifdef INST_FEEDER_WAIT_EN
   logic [3:0]          wait_cnt;
`endif

   assign busy      = (state != IDLE) && (state != DONE);
   assign redir_hit = redirect && (state != IDLE);
   assign restart   = start && busy;
   assign launch    = start && !busy;
   assign can_issue = !inst_valid || out_ready;

   // A fresh start fetches address 0 on the same edge, unless a load shares
   // that cycle, in which case the write lands first and fetch waits a cycle.
   always_comb begin
      len_in = (prog_len > DEPTH_LEN) ? DEPTH_LEN : prog_len;
      target = {1'b0, redirect_addr};
      if (LANES == 2) target[0] = 1'b0;
      fetch_addr = launch ? '0 : pc;
      fetch_len  = launch ? len_in : len;
      if (redir_hit)
         fetch = 1'b0;
      else if (launch)
         fetch = !load_en && (len_in != '0);
      else
         fetch = !restart && (state == RUN) && can_issue && (pc < len);
   end

   always_comb begin
      beat = '0;
      for (int i = 0; i < LANES; i++) begin
         if (({1'b0, fetch_addr} + (PW+1)'(i)) < {1'b0, fetch_len})
            beat[16*i +: 16] = mem[fetch_addr[ADDR_W-1:0] + ADDR_W'(i)];
         else
            beat[16*i +: 16] = PAD_HW;
      end
   end

   always_ff @(posedge clk) begin
      if (load_en && !busy) mem[load_addr] <= load_data;
   end

   // Priority is reset, redirect, start, then the normal fetch sequence.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         len        <= '0;
         pc         <= '0;
         inst_hw    <= '0;
         inst_valid <= 1'b0;
         done       <= 1'b0;
`ifdef INST_FEEDER_WAIT_EN
         wait_cnt   <= 4'd0;
`endif
      end else begin
         if (redir_hit) begin
            inst_valid <= 1'b0;
            done       <= 1'b0;
            pc         <= target;
            state      <= RUN;
         end else if (restart) begin
            inst_valid <= 1'b0;
            pc         <= '0;
            len        <= len_in;
            state      <= RUN;
         end else if (launch) begin
            len   <= len_in;
            done  <= 1'b0;
            pc    <= '0;
            state <= RUN;
         end else begin
            case (state)
               RUN: begin
                  if (can_issue && !fetch) begin
                     state      <= DONE;
                     done       <= 1'b1;
                     inst_valid <= 1'b0;
                  end
               end
`ifdef INST_FEEDER_WAIT_EN
               WAIT: begin
                  if (out_ready) inst_valid <= 1'b0;
                  if (wait_cnt == 4'd0)
                     state <= RUN;
                  else
                     wait_cnt <= wait_cnt - 4'd1;
               end
`endif
               default: ;
            endcase
         end

         if (fetch) begin
            inst_hw    <= beat;
            inst_valid <= 1'b1;
            pc         <= fetch_addr + STEP;
            state      <= RUN;
`ifdef INST_FEEDER_WAIT_EN
            if (WAIT_CYCLES > 0) begin
               state    <= WAIT;
               wait_cnt <= 4'(WAIT_CYCLES - 1);
            end
`endif
         end
      end
   end
endmodule
